// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state encoding
// and the digit-count helper used to size the digit counter.
package addsub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Number of DIGIT-wide slices in a WIDTH-bit operand.
    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/response bundle of the digit-serial adder/subtractor.
// The master issues operands with start; the slave reports status and results.
interface serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, sum, carry, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, sum, carry, overflow
    );
endinterface

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple adder slice. Besides the carry out of the top
// bit it exposes the carry into the top bit, which the parent needs to derive
// signed overflow on the final digit.
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);
    logic [DIGIT:0] carry_s;

    // Bit-by-bit ripple: full-adder sum and carry for each position.
    always_comb begin
        carry_s    = {(DIGIT+1){1'b0}};
        s          = {DIGIT{1'b0}};
        carry_s[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]         = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry_s[DIGIT];
    assign cmsb = carry_s[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor. Operands are latched on accept and consumed
// one DIGIT-wide slice per clock, LSB first, through a single ripple slice with
// a registered carry. Subtraction is a + ~b + 1, so the carry register is
// seeded with the sub flag. The result register shifts in each new digit at the
// top, so after the last digit the first one has arrived at the bottom.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    serial_addsub_if.slave bus
);
    localparam int             NDIG     = ndig(WIDTH, DIGIT);
    localparam int             CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(NDIG - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_cout_s;
    logic             dig_cmsb_s;

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (c_q),
        .s    (dig_s),
        .cout (dig_cout_s),
        .cmsb (dig_cmsb_s)
    );

    // Next-state logic: accept in IDLE/DONE, one digit per cycle in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    cnt_d   = {CW{1'b0}};
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    c_d     = bus.sub;
                    sum_d   = {WIDTH{1'b0}};
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                c_d   = dig_cout_s;
                sum_d = (sum_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = {CW{1'b0}};
                    carry_d = dig_cout_s;
                    ovf_d   = dig_cout_s ^ dig_cmsb_s;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            c_q     <= 1'b0;
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.sum      = sum_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;

endmodule
